// File: rtl/bitwise_decode_if.sv
// bitwise_decode_if: operand/result stream in, recovered-operand stream out, error counter access
interface bitwise_decode_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;
  logic err;
  logic clr_cnt;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res_and;
  logic [WIDTH-1:0] res_or;
  logic [WIDTH-1:0] res_xor;
  logic [WIDTH-1:0] a_rec;
  logic [CNT_W-1:0] err_cnt;
  modport master (
    output s_valid, b, res_and, res_or, res_xor, m_ready, clr_cnt,
    input  s_ready, m_valid, a_rec, err, err_cnt
  );
  modport slave (
    input  s_valid, b, res_and, res_or, res_xor, m_ready, clr_cnt,
    output s_ready, m_valid, a_rec, err, err_cnt
  );
endinterface

// File: rtl/bitwise_decode.sv
// bitwise_decode: recovers a = xor ^ b over a 2-stage valid/ready pipe, flags and/or inconsistency, counts errors
module bitwise_decode #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  bitwise_decode_if.slave bus
);
  logic             s1_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             err_nxt;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_and;
  logic [WIDTH-1:0] s1_or;
  logic [WIDTH-1:0] s1_xor;
  logic [WIDTH-1:0] a_nxt;
  always_comb begin
    s2_adv  = ~bus.m_valid | bus.m_ready;
    s1_adv  = ~s1_valid | s2_adv;
    a_nxt   = s1_xor ^ s1_b;
    err_nxt = (s1_and != (a_nxt & s1_b)) | (s1_or != (a_nxt | s1_b));
  end
  assign bus.s_ready = s1_adv & rst_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_b        <= '0;
      s1_and      <= '0;
      s1_or       <= '0;
      s1_xor      <= '0;
      bus.m_valid <= 1'b0;
      bus.a_rec   <= '0;
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.s_valid;
        if (bus.s_valid) begin
          s1_b   <= bus.b;
          s1_and <= bus.res_and;
          s1_or  <= bus.res_or;
          s1_xor <= bus.res_xor;
        end
      end
      if (s2_adv) begin
        bus.m_valid <= s1_valid;
        if (s1_valid) begin
          bus.a_rec <= a_nxt;
          bus.err   <= err_nxt;
        end
      end
      if (bus.clr_cnt)
        bus.err_cnt <= '0;
      else if (bus.m_valid & bus.m_ready & bus.err & ~&bus.err_cnt)
        bus.err_cnt <= bus.err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bitwise_decode.sv
// tb_bitwise_decode: directed spec scenarios plus random traffic checked against a transaction-queue model
module tb_bitwise_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bitwise_decode_if #(.WIDTH(4), .CNT_W(2)) bus ();
  bitwise_decode #(.WIDTH(4), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [3:0] a;
    logic       e;
    int         n;
  } item_t;
  item_t q[$];
  int checks = 0;
  int errors = 0;
  int edges = 0;
  int cnt_m = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic item_t mk(logic [3:0] b, logic [3:0] an, logic [3:0] o, logic [3:0] x, int n);
    item_t t;
    t.a = x ^ b;
    t.e = (an != (t.a & b)) || (o != (t.a | b));
    t.n = n;
    return t;
  endfunction
  task automatic drive(bit v, logic [3:0] b, logic [3:0] an, logic [3:0] o, logic [3:0] x);
    bus.s_valid = v;
    bus.b       = b;
    bus.res_and = an;
    bus.res_or  = o;
    bus.res_xor = x;
  endtask
  task automatic drive_rnd(bit v, int bad);
    logic [3:0] a = 4'($urandom);
    logic [3:0] b = 4'($urandom);
    logic [3:0] m = 4'b0001 << $urandom_range(3);
    logic [3:0] an = a & b;
    logic [3:0] o = a | b;
    if (bad == 1) an ^= m;
    if (bad == 2) o ^= m;
    drive(v, b, an, o, a ^ b);
  endtask
  task automatic tick(output bit acc, output bit ohs);
    bit hold;
    bit rst_now;
    logic [3:0] ha;
    logic he;
    item_t h;
    #1;
    rst_now = !rst_n;
    acc = rst_n && bus.s_valid && bus.s_ready;
    ohs = rst_n && bus.m_valid && bus.m_ready;
    hold = rst_n && bus.m_valid && !bus.m_ready;
    ha = bus.a_rec;
    he = bus.err;
    if (rst_now) begin
      check("s_ready_in_reset", bus.s_ready, 0);
      q.delete();
      cnt_m = 0;
    end else begin
      check("s_ready", bus.s_ready, !(q.size() == 2 && !bus.m_ready));
      check("m_valid", bus.m_valid, q.size() > 0 ? (edges >= q[0].n + 1) : 0);
      if (ohs) begin
        if (q.size() == 0) check("spurious_out", q.size(), 1);
        else begin
          h = q.pop_front();
          check("a_rec", ha, h.a);
          check("err", he, h.e);
          if (h.e && cnt_m < 3) cnt_m++;
        end
      end
      if (bus.clr_cnt) cnt_m = 0;
      if (acc) q.push_back(mk(bus.b, bus.res_and, bus.res_or, bus.res_xor, edges + 1));
    end
    @(posedge clk);
    edges++;
    #1;
    if (rst_now) begin
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_a_rec", bus.a_rec, 0);
      check("rst_err", bus.err, 0);
      check("rst_err_cnt", bus.err_cnt, 0);
    end else begin
      check("err_cnt", bus.err_cnt, cnt_m);
      if (hold) begin
        check("hold_m_valid", bus.m_valid, 1);
        check("hold_a_rec", bus.a_rec, ha);
        check("hold_err", bus.err, he);
      end
    end
  endtask
  task automatic idle(int n);
    bit acc, ohs;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      tick(acc, ohs);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bit acc, ohs, stalled;
    int sent, outs;
    logic [31:0] vals[5];
    drive(0, 0, 0, 0, 0);
    bus.m_ready = 1'b1;
    bus.clr_cnt = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tick(acc, ohs);
    end
    // scenario 1: clean transaction, latency
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 4'b1010, 4'b0010, 4'b1110, 4'b1100);
    tick(acc, ohs);
    check("t1_accept", acc, 1);
    check("t1_mvalid_after_accept", bus.m_valid, 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    tick(acc, ohs);
    check("t1_mvalid_next", bus.m_valid, 1);
    check("t1_a_rec", bus.a_rec, 4'b0110);
    check("t1_err", bus.err, 0);
    idle(1);
    check("t1_err_cnt", bus.err_cnt, 0);
    // scenario 2: bad OR result
    @(negedge clk);
    drive(1, 4'b1010, 4'b0010, 4'b1111, 4'b1100);
    tick(acc, ohs);
    idle(1);
    check("t2_a_rec", bus.a_rec, 4'b0110);
    check("t2_err", bus.err, 1);
    check("t2_cnt_before", bus.err_cnt, 0);
    idle(1);
    check("t2_cnt_after", bus.err_cnt, 1);
    // scenario 3: back-to-back with downstream stall
    sent = 0;
    outs = 0;
    stalled = 0;
    for (int c = 0; c < 30 && outs < 4; c++) begin
      @(negedge clk);
      bus.m_ready = (c >= 3);
      if (sent < 4) drive_rnd(1, 0);
      else bus.s_valid = 1'b0;
      tick(acc, ohs);
      if (sent < 4 && !acc) stalled = 1;
      if (acc) sent++;
      if (ohs) outs++;
    end
    check("t3_stalled", stalled, 1);
    check("t3_delivered", outs, 4);
    // scenario 4: counter saturation
    @(negedge clk);
    bus.clr_cnt = 1'b1;
    bus.s_valid = 1'b0;
    tick(acc, ohs);
    bus.clr_cnt = 1'b0;
    sent = 0;
    outs = 0;
    for (int c = 0; c < 30 && outs < 5; c++) begin
      @(negedge clk);
      if (sent < 5) drive_rnd(1, 1 + (c % 2));
      else bus.s_valid = 1'b0;
      tick(acc, ohs);
      if (acc) sent++;
      if (ohs) begin
        vals[outs] = 32'(bus.err_cnt);
        outs++;
      end
    end
    check("t4_outs", outs, 5);
    check("t4_cnt0", vals[0], 1);
    check("t4_cnt1", vals[1], 2);
    check("t4_cnt2", vals[2], 3);
    check("t4_cnt3", vals[3], 3);
    check("t4_cnt4", vals[4], 3);
    // scenario 5: clear wins over coincident increment
    @(negedge clk);
    bus.m_ready = 1'b0;
    drive_rnd(1, 1);
    tick(acc, ohs);
    for (int c = 0; c < 5 && !bus.m_valid; c++) idle(1);
    check("t5_waiting", bus.m_valid, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    bus.clr_cnt = 1'b1;
    tick(acc, ohs);
    bus.clr_cnt = 1'b0;
    check("t5_handshake", ohs, 1);
    check("t5_cleared", bus.err_cnt, 0);
    @(negedge clk);
    drive_rnd(1, 2);
    tick(acc, ohs);
    idle(2);
    check("t5_after", bus.err_cnt, 1);
    // scenario 6: reset with both stages full
    bus.m_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 10 && sent < 2; c++) begin
      @(negedge clk);
      drive_rnd(1, 0);
      tick(acc, ohs);
      if (acc) sent++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    check("t6_full", bus.s_ready, 0);
    tick(acc, ohs);
    @(negedge clk);
    rst_n = 1'b0;
    tick(acc, ohs);
    check("t6_m_valid", bus.m_valid, 0);
    check("t6_err_cnt", bus.err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_ready_after", bus.s_ready, 1);
    tick(acc, ohs);
    // random traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(99) != 0);
      bus.m_ready = ($urandom_range(3) != 0);
      bus.clr_cnt = ($urandom_range(29) == 0);
      drive_rnd($urandom_range(3) != 0, $urandom_range(2));
      tick(acc, ohs);
    end
    rst_n = 1'b1;
    bus.clr_cnt = 1'b0;
    bus.m_ready = 1'b1;
    idle(4);
    check("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
